// File: rtl/bus_arb_pkg.sv
// Shared types and bus address map for the budget-limited bid arbiter.
package bus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam logic [15:0] BUS_BASE_HI = 16'hFFEF;
  localparam logic [3:0]  BUS_TAG     = 4'h2;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } slave_dec_t;

  // Slave window: FFEF_[00ss]2xx, slave index taken from addr[13:12].
  function automatic slave_dec_t decode_slave(input logic [31:0] addr);
    slave_dec_t d;
    logic       unused_lo;
    unused_lo = ^addr[7:0];
    d.valid = (addr[31:16] == BUS_BASE_HI) && (addr[15:14] == 2'b00) &&
              (addr[11:8] == BUS_TAG);
    d.idx   = addr[13:12];
    return d;
  endfunction

endpackage

// File: rtl/bid_budget_bank.sv
// Per-master credit balances with periodic saturating refill.
module bid_budget_bank #(
  parameter int               NM       = 4,
  parameter int               BID_W    = 8,
  parameter int               BAL_W    = 12,
  parameter logic [BAL_W-1:0] MAX_BAL  = 12'd1000,
  parameter logic [BAL_W-1:0] REFILL   = 12'd100,
  parameter int               INTERVAL = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   charge_en,
  input  logic [$clog2(NM)-1:0]  charge_idx,
  input  logic [BID_W-1:0]       charge_amt,
  output logic [NM*BAL_W-1:0]    bal
);

  localparam int CNT_W = $clog2(INTERVAL);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(INTERVAL - 1));

  always_ff @(posedge clk) begin
    if (!rst)        r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NM; gi++) begin : g_bal
      logic [BAL_W-1:0] r_bal;
      logic [BAL_W:0]   w_base;
      logic [BAL_W:0]   w_sum;

      // One spare bit so charge-then-refill can exceed MAX_BAL before clamping.
      assign w_base = {1'b0, r_bal} -
                      ((charge_en && (charge_idx == ($clog2(NM))'(gi))) ?
                       (BAL_W+1)'(charge_amt) : '0);
      assign w_sum  = w_wrap ? (w_base + (BAL_W+1)'(REFILL)) : w_base;

      always_ff @(posedge clk) begin
        if (!rst)
          r_bal <= MAX_BAL;
        else if (w_sum > (BAL_W+1)'(MAX_BAL))
          r_bal <= MAX_BAL;
        else
          r_bal <= w_sum[BAL_W-1:0];
      end

      assign bal[gi*BAL_W +: BAL_W] = r_bal;
    end
  endgenerate

endmodule

// File: rtl/bid_budget_arb.sv
// Budget-limited bidding arbiter with one-hot slave decode.
// Optional bus watchdog enabled by defining ARB_TIMEOUT_EN.
module bid_budget_arb
  import bus_arb_pkg::*;
#(
  parameter int               NM       = 4,
  parameter int               BID_W    = 8,
  parameter int               BAL_W    = 12,
  parameter logic [BAL_W-1:0] MAX_BAL  = 12'd1000,
  parameter logic [BAL_W-1:0] REFILL   = 12'd100,
  parameter int               INTERVAL = 64,
  parameter int               TIMEOUT  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NM-1:0]           req,
  input  logic [NM*BID_W-1:0]     bid,
  input  logic [NM*32-1:0]        addr,
  input  logic                    ack,
  output logic [NM-1:0]           grant,
  output logic [3:0]              sel,
  output logic [$clog2(NM)-1:0]   gnt_idx,
  output logic                    err,
  output logic [NM*BAL_W-1:0]     bal
);

  localparam int IDX_W = $clog2(NM);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  arb_state_t       r_state, w_state_next;
  logic [NM-1:0]    r_grant, w_grant_next;
  logic [3:0]       r_sel, w_sel_next;
  logic [IDX_W-1:0] r_gnt_idx, w_gnt_idx_next;
  logic             r_err, w_err_next;
  logic [TO_W-1:0]  r_busy_cnt;
  logic             w_timeout;

  logic [NM-1:0]    w_elig;
  logic             w_any;
  logic [IDX_W-1:0] w_win;
  logic [BID_W-1:0] w_win_bid;
  logic [31:0]      w_win_addr;
  slave_dec_t       w_dec;
  logic             w_charge_en;

  genvar gi;
  generate
    for (gi = 0; gi < NM; gi++) begin : g_elig
      assign w_elig[gi] = req[gi] && (bid[gi*BID_W +: BID_W] != '0) &&
                          (BAL_W'(bid[gi*BID_W +: BID_W]) <= bal[gi*BAL_W +: BAL_W]);
    end
  endgenerate

  // Strict '>' while scanning upward keeps ties with the lowest index.
  always_comb begin
    w_any     = 1'b0;
    w_win     = '0;
    w_win_bid = '0;
    for (int i = 0; i < NM; i++) begin
      if (w_elig[i] && (!w_any || (bid[i*BID_W +: BID_W] > w_win_bid))) begin
        w_any     = 1'b1;
        w_win     = IDX_W'(i);
        w_win_bid = bid[i*BID_W +: BID_W];
      end
    end
  end

  assign w_win_addr = addr[w_win*32 +: 32];
  assign w_dec      = decode_slave(w_win_addr);
  assign w_timeout  = TO_EN && (r_state == BUSY) && (r_busy_cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    w_state_next   = r_state;
    w_grant_next   = r_grant;
    w_sel_next     = r_sel;
    w_gnt_idx_next = r_gnt_idx;
    w_err_next     = 1'b0;
    w_charge_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          if (w_dec.valid) begin
            w_grant_next   = NM'(1) << w_win;
            w_sel_next     = 4'd1 << w_dec.idx;
            w_gnt_idx_next = w_win;
            w_charge_en    = 1'b1;
            w_state_next   = BUSY;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end
      BUSY: begin
        if (ack || w_timeout) begin
          w_grant_next   = '0;
          w_sel_next     = '0;
          w_gnt_idx_next = '0;
          w_err_next     = !ack;
          w_state_next   = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_sel     <= '0;
      r_gnt_idx <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_grant   <= w_grant_next;
      r_sel     <= w_sel_next;
      r_gnt_idx <= w_gnt_idx_next;
      r_err     <= w_err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || (r_state != BUSY)) r_busy_cnt <= '0;
    else                           r_busy_cnt <= r_busy_cnt + 1'b1;
  end

  bid_budget_bank #(
    .NM       (NM),
    .BID_W    (BID_W),
    .BAL_W    (BAL_W),
    .MAX_BAL  (MAX_BAL),
    .REFILL   (REFILL),
    .INTERVAL (INTERVAL)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .charge_en  (w_charge_en),
    .charge_idx (w_win),
    .charge_amt (w_win_bid),
    .bal        (bal)
  );

  assign grant   = r_grant;
  assign sel     = r_sel;
  assign gnt_idx = r_gnt_idx;
  assign err     = r_err;

endmodule

// File: tb/tb_bid_budget_arb.sv
// Directed self-checking bench for bid_budget_arb (define ARB_TIMEOUT_EN for the watchdog case).
module tb_bid_budget_arb;

  localparam int TIMEOUT = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [31:0]  bid;
  logic [127:0] addr;
  logic         ack;
  logic [3:0]   grant;
  logic [3:0]   sel;
  logic [1:0]   gnt_idx;
  logic         err;
  logic [47:0]  bal;

  int errors = 0;
  int checks = 0;
  int n = 0;

  always #5 clk = ~clk;

  bid_budget_arb dut (
    .clk(clk), .rst(rst), .req(req), .bid(bid), .addr(addr), .ack(ack),
    .grant(grant), .sel(sel), .gnt_idx(gnt_idx), .err(err), .bal(bal)
  );

  function automatic logic [11:0] bal_of(input int i);
    return bal[i*12 +: 12];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic set_m(input int i, input logic r, input logic [7:0] b, input logic [31:0] a);
    req[i]         = r;
    bid[i*8 +: 8]  = b;
    addr[i*32 +: 32] = a;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; bid = '0; addr = '0; ack = 1'b0;
    step();
    rst = 1'b1;
    n = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (sel !== 4'b0000) begin errors++; $display("FAIL reset_sel got=%b exp=0000", sel); end
    checks++; if (gnt_idx !== 2'd0 || err !== 1'b0) begin errors++; $display("FAIL reset_idx_err got=%0d/%b exp=0/0", gnt_idx, err); end
    checks++; if (bal !== {4{12'd1000}}) begin errors++; $display("FAIL reset_bal got=%h exp=all 1000", bal); end
    $display("reset: grant=%b sel=%b bal=%h", grant, sel, bal);
  endtask

  task automatic test_single();
    do_reset();
    set_m(0, 1'b1, 8'd50, 32'hFFEF_2200);
    step();
    $display("single: grant=%b sel=%b bal0=%0d", grant, sel, bal_of(0));
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant got=%b exp=0001", grant); end
    checks++; if (sel !== 4'b0100) begin errors++; $display("FAIL single_sel got=%b exp=0100", sel); end
    checks++; if (bal_of(0) !== 12'd950) begin errors++; $display("FAIL single_bal0 got=%0d exp=950", bal_of(0)); end
    req = '0;
    step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_hold got=%b exp=0001", grant); end
    ack = 1'b1;
    step();
    checks++; if (grant !== 4'b0000 || sel !== 4'b0000) begin errors++; $display("FAIL single_ack got=%b/%b exp=0000/0000", grant, sel); end
    step();
    checks++; if (grant !== 4'b0000 || err !== 1'b0 || bal_of(0) !== 12'd950) begin
      errors++; $display("FAIL idle_ack got=%b/%b/%0d exp=0000/0/950", grant, err, bal_of(0)); end
    ack = 1'b0;
  endtask

  task automatic test_tie();
    do_reset();
    set_m(0, 1'b1, 8'd10, 32'hFFEF_0200);
    set_m(1, 1'b1, 8'd40, 32'hFFEF_1200);
    set_m(2, 1'b1, 8'd40, 32'hFFEF_2200);
    set_m(3, 1'b1, 8'd5,  32'hFFEF_3200);
    step();
    $display("tie: grant=%b idx=%0d bal1=%0d", grant, gnt_idx, bal_of(1));
    checks++; if (grant !== 4'b0010 || gnt_idx !== 2'd1) begin errors++; $display("FAIL tie_grant got=%b/%0d exp=0010/1", grant, gnt_idx); end
    checks++; if (sel !== 4'b0010) begin errors++; $display("FAIL tie_sel got=%b exp=0010", sel); end
    checks++; if (bal_of(1) !== 12'd960 || bal_of(2) !== 12'd1000) begin
      errors++; $display("FAIL tie_bal got=%0d/%0d exp=960/1000", bal_of(1), bal_of(2)); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    checks++; if (grant !== 4'b0000 || gnt_idx !== 2'd0) begin errors++; $display("FAIL tie_release got=%b/%0d exp=0000/0", grant, gnt_idx); end
    step();
    $display("tie2: grant=%b bal1=%0d", grant, bal_of(1));
    checks++; if (grant !== 4'b0010 || bal_of(1) !== 12'd920) begin
      errors++; $display("FAIL tie_regrant got=%b/%0d exp=0010/920", grant, bal_of(1)); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    set_m(3, 1'b1, 8'd200, 32'hFFEF_3200);
    step();
    $display("high: grant=%b sel=%b bal3=%0d", grant, sel, bal_of(3));
    checks++; if (grant !== 4'b1000 || sel !== 4'b1000 || bal_of(3) !== 12'd800) begin
      errors++; $display("FAIL high_bid got=%b/%b/%0d exp=1000/1000/800", grant, sel, bal_of(3)); end
  endtask

  task automatic test_budget();
    logic [11:0] exp_bal;
    do_reset();
    set_m(0, 1'b1, 8'd255, 32'hFFEF_0200);
    set_m(3, 1'b1, 8'd1,   32'hFFEF_3200);
    exp_bal = 12'd1000;
    for (int k = 0; k < 3; k++) begin
      step();
      exp_bal = exp_bal - 12'd255;
      $display("budget win %0d: grant=%b bal0=%0d", k, grant, bal_of(0));
      checks++; if (grant !== 4'b0001 || bal_of(0) !== exp_bal) begin
        errors++; $display("FAIL budget_win%0d got=%b/%0d exp=0001/%0d", k, grant, bal_of(0), exp_bal); end
      ack = 1'b1;
      step();
      ack = 1'b0;
    end
    step();
    $display("budget poor: grant=%b bal0=%0d bal3=%0d", grant, bal_of(0), bal_of(3));
    checks++; if (grant !== 4'b1000 || bal_of(3) !== 12'd999 || bal_of(0) !== 12'd235) begin
      errors++; $display("FAIL budget_poor got=%b/%0d/%0d exp=1000/999/235", grant, bal_of(3), bal_of(0)); end
    req = '0;
    ack = 1'b1;
    step();
    ack = 1'b0;
    while (n < 63) step();
    checks++; if (bal_of(0) !== 12'd235) begin errors++; $display("FAIL pre_refill got=%0d exp=235", bal_of(0)); end
    step();
    $display("refill: bal0=%0d bal3=%0d", bal_of(0), bal_of(3));
    checks++; if (bal_of(0) !== 12'd335 || bal_of(3) !== 12'd1000) begin
      errors++; $display("FAIL refill got=%0d/%0d exp=335/1000", bal_of(0), bal_of(3)); end
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (200) step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (bal_of(i) !== 12'd1000) begin errors++; $display("FAIL sat_idle%0d got=%0d exp=1000", i, bal_of(i)); end
    end
    while (n < 255) step();
    set_m(0, 1'b1, 8'd100, 32'hFFEF_0200);
    step();
    $display("wrap charge: n=%0d grant=%b bal0=%0d", n, grant, bal_of(0));
    checks++; if (grant !== 4'b0001 || bal_of(0) !== 12'd1000) begin
      errors++; $display("FAIL sat_wrap got=%b/%0d exp=0001/1000", grant, bal_of(0)); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    checks++; if (grant !== 4'b0001 || bal_of(0) !== 12'd900) begin
      errors++; $display("FAIL sat_nowrap got=%b/%0d exp=0001/900", grant, bal_of(0)); end
    req = '0;
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic test_decode_err();
    do_reset();
    set_m(2, 1'b1, 8'd30, 32'hFFEE_0200);
    step();
    $display("decode bad base: err=%b grant=%b bal2=%0d", err, grant, bal_of(2));
    checks++; if (err !== 1'b1 || grant !== 4'b0000 || sel !== 4'b0000) begin
      errors++; $display("FAIL dec_base got=%b/%b/%b exp=1/0000/0000", err, grant, sel); end
    checks++; if (bal_of(2) !== 12'd1000) begin errors++; $display("FAIL dec_nocharge got=%0d exp=1000", bal_of(2)); end
    req = '0;
    step();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL dec_pulse got=%b exp=0", err); end
    set_m(0, 1'b1, 8'd20, 32'hFFEF_0200);
    set_m(1, 1'b1, 8'd30, 32'hFFEF_6200);
    step();
    checks++; if (err !== 1'b1 || grant !== 4'b0000 || bal_of(1) !== 12'd1000 || bal_of(0) !== 12'd1000) begin
      errors++; $display("FAIL dec_mid got=%b/%b/%0d exp=1/0000/1000", err, grant, bal_of(1)); end
    set_m(1, 1'b1, 8'd30, 32'hFFEF_1300);
    step();
    checks++; if (err !== 1'b1 || grant !== 4'b0000) begin errors++; $display("FAIL dec_tag got=%b/%b exp=1/0000", err, grant); end
    set_m(1, 1'b1, 8'd30, 32'hFFEF_1200);
    step();
    $display("decode fixed: err=%b grant=%b bal1=%0d", err, grant, bal_of(1));
    checks++; if (err !== 1'b0 || grant !== 4'b0010 || bal_of(1) !== 12'd970) begin
      errors++; $display("FAIL dec_retry got=%b/%b/%0d exp=0/0010/970", err, grant, bal_of(1)); end
    req = '0;
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic test_reset_busy();
    do_reset();
    set_m(0, 1'b1, 8'd50, 32'hFFEF_1200);
    step();
    checks++; if (grant !== 4'b0001 || bal_of(0) !== 12'd950) begin
      errors++; $display("FAIL rb_grant got=%b/%0d exp=0001/950", grant, bal_of(0)); end
    rst = 1'b0;
    step();
    $display("reset busy: grant=%b sel=%b bal=%h", grant, sel, bal);
    checks++; if (grant !== 4'b0000 || sel !== 4'b0000 || err !== 1'b0) begin
      errors++; $display("FAIL rb_clear got=%b/%b/%b exp=0000/0000/0", grant, sel, err); end
    checks++; if (bal !== {4{12'd1000}}) begin errors++; $display("FAIL rb_bal got=%h exp=all 1000", bal); end
    rst = 1'b1;
    req = '0;
  endtask

  task automatic test_watchdog();
    do_reset();
    set_m(0, 1'b1, 8'd10, 32'hFFEF_0200);
    step();
    req = '0;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL wd_grant got=%b exp=0001", grant); end
`ifdef ARB_TIMEOUT_EN
    repeat (TIMEOUT - 1) step();
    checks++; if (grant !== 4'b0001 || err !== 1'b0) begin
      errors++; $display("FAIL wd_early got=%b/%b exp=0001/0", grant, err); end
    step();
    $display("watchdog: grant=%b err=%b bal0=%0d", grant, err, bal_of(0));
    checks++; if (grant !== 4'b0000 || sel !== 4'b0000 || err !== 1'b1 || bal_of(0) !== 12'd990) begin
      errors++; $display("FAIL wd_fire got=%b/%b/%b/%0d exp=0000/0000/1/990", grant, sel, err, bal_of(0)); end
    step();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wd_pulse got=%b exp=0", err); end
`else
    repeat (TIMEOUT + 8) step();
    $display("no watchdog: grant=%b err=%b", grant, err);
    checks++; if (grant !== 4'b0001 || err !== 1'b0) begin
      errors++; $display("FAIL wd_hold got=%b/%b exp=0001/0", grant, err); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL wd_ack got=%b exp=0000", grant); end
`endif
  endtask

  initial begin
    rst = 1'b0; req = '0; bid = '0; addr = '0; ack = 1'b0;
    test_reset();
    test_single();
    test_tie();
    test_budget();
    test_saturation();
    test_decode_err();
    test_reset_busy();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bid_budget_arb.md
# bid_budget_arb

Budget-limited bidding arbiter for the four-master/four-slave bus. Each master offers a bid each cycle and holds a credit balance. The highest affordable bid wins the bus, and the winning bid is charged to the winner's balance. Balances refill at a fixed interval, so no master can monopolise the bus. The block decodes the winner's address to a one-hot slave select and holds the grant until the slave acknowledges.

## Interface
- NM, 4, number of masters (the decode logic is fixed at 4 slaves).
- BID_W, 8, bid width.
- BAL_W, 12, balance width.
- MAX_BAL, 12'd1000, balance ceiling and reset value.
- REFILL, 12'd100, credit added to every balance per interval.
- INTERVAL, 64, refill period in cycles (≥2).
- TIMEOUT, 32, watchdog limit in cycles (used only with ARB_TIMEOUT_EN).
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; synchronous and active-low.
- req  in  NM  per-master request valid.
- bid  in  NM×BID_W  per-master bid, unsigned.
- addr  in  NM×32  per-master target address.
- ack  in  1  slave transfer-complete pulse.
- grant  out  NM  one-hot grant; reset 0.
- sel  out  4  one-hot slave select; reset 0.
- gnt_idx  out  2  index of the granted master; reset 0.
- err  out  1  one-cycle error pulse; reset 0.
- bal  out  NM×BAL_W  current balances; reset MAX_BAL each.

## Operation
- The state machine has two states, IDLE and BUSY. Reset enters IDLE.
- Master i is eligible in IDLE when req[i]=1, bid[i]≠0 and bid[i]≤bal[i].
- Winner selection:
  - The winner is the eligible master with the largest bid.
  - A tie goes to the lowest index.
  - If no master is eligible, the block stays in IDLE and outputs stay 0.
- Address decode of the winner's address:
  - Valid only if addr[31:16]=16'hFFEF, addr[15:14]=0 and addr[11:8]=4'h2.
  - The slave index is addr[13:12].
- Valid decode:
  - grant[w], sel[s] and gnt_idx=w are registered.
  - bal[w] is reduced by bid[w].
  - The state goes to BUSY.
- Invalid decode:
  - err pulses for 1 cycle.
  - There is no grant and no charge, and the state stays in IDLE.
  - The offending master may win again on the next cycle.
- In BUSY:
  - req, bid and addr are ignored.
  - On ack=1, grant and sel clear and the state returns to IDLE.
- Refill:
  - A free-running counter runs 0..INTERVAL-1. At its wrap, every balance gets +REFILL, saturating at MAX_BAL.
  - The refill applies in both states.
- Charge and refill in the same cycle: bal = min(MAX_BAL, bal − bid + REFILL). The subtraction never underflows because eligibility guarantees bid ≤ bal.
- Reset mid-transfer:
  - grant, sel and err clear and the state goes to IDLE.
  - Balances return to MAX_BAL and the refill counter returns to 0.
- An ack received in IDLE is ignored.

## Timing
- The arbitration decision is combinational on IDLE-cycle inputs. grant and sel are visible on the following edge, so request-to-grant latency is 1 cycle.
- The balance charge appears on the same edge as grant.
- When ack is sampled high in BUSY, grant and sel drop on the next edge.
- The earliest next grant is 2 cycles after ack: one IDLE cycle is mandatory.
- err is asserted exactly 1 cycle and is registered on the same edge the grant would have been.
- Refill lands on the edge where the counter wraps from INTERVAL-1 to 0. The first refill is INTERVAL cycles after reset is released.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A BUSY-cycle counter runs while in BUSY.
  - If TIMEOUT cycles pass without ack, grant and sel clear, err pulses for 1 cycle and the state returns to IDLE.
  - The charge is not refunded.
- ARB_TIMEOUT_EN undefined: BUSY waits for ack indefinitely, and err arises only from decode errors.

## Structure
- Package bus_arb_pkg:
  - state enum arb_state_t {IDLE, BUSY};
  - address constants BUS_BASE_HI=16'hFFEF and BUS_TAG=4'h2;
  - function decode_slave(addr) returning {valid, idx}.
- Sub-module bid_budget_bank: holds the NM balance registers and the refill counter. It takes charge_en, charge_idx and charge_amt and outputs bal. The top level contains the FSM, the winner selection and the decode.

## Test plan
- Single request: after reset, req=4'b0001, bid0=50, addr0=FFEF_2200. Required: grant=0001 and sel=0100 after 1 cycle, and bal0=950. ack → grant=0 on the next edge.
- Bidding and ties:
  - bid={m0:10, m1:40, m2:40, m3:5}, all requesting → m1 wins and bal1=960.
  - m1 and m2 both at 40 with nothing higher → m1 wins.
- Budget exhaustion: m0 repeatedly bids 255 and wins 3 times (bal0=235). On the next round, m3 (bid 1) wins over m0 (bid 255 > bal). After the refill, bal0=335.
- Refill saturation: all balances start at MAX_BAL with no requests for 200 cycles → balances stay 1000. A charge of 100 landing on the wrap edge → that balance reads 1000.
- Decode error: addr=FFEE_0200 → err pulses for 1 cycle, no grant, balance unchanged.
- Reset and watchdog:
  - rst=0 during BUSY → next edge gives grant=0, sel=0, all bal=1000.
  - With ARB_TIMEOUT_EN and no ack → err is asserted TIMEOUT cycles after the grant, and grant clears.
